// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: operation codes, FSM states and code legality check for serial_alu.
package serial_alu_pkg;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // case matches exactly, so X/Z codes fall through to illegal
    function automatic logic is_legal(input logic [2:0] code);
        case (code)
            ALUCTL_ADD, ALUCTL_SUB, ALUCTL_AND, ALUCTL_OR, ALUCTL_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/serial_alu_alu_digit.sv
// alu_digit: combinational DIGIT-bit slice of the serial ALU (sum, logic ops, carries).
module alu_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_digit,
    input  logic [DIGIT-1:0] b_digit,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [DIGIT-1:0] res_digit,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   sum;

    // SUB and SLT are the only codes with op[2] set; both add ~b with carry-in 1
    always_comb begin
        b_eff     = op[2] ? ~b_digit : b_digit;
        sum       = {1'b0, a_digit} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
        cout      = sum[DIGIT];
        c_msb     = sum[DIGIT-1] ^ a_digit[DIGIT-1] ^ b_eff[DIGIT-1];
        res_digit = op == ALUCTL_AND ? a_digit & b_digit :
                    op == ALUCTL_OR  ? a_digit | b_digit : sum[DIGIT-1:0];
    end
endmodule

// File: rtl/serial_alu.sv
// serial_alu: digit-serial ALU (ADD/SUB/AND/OR/SLT), LSB first, valid/ready on both sides.
// Define ALU_OVF_EN to expose the signed-overflow output ovf.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, final_res;
    logic [2:0]       op_q;
    logic             carry, cout, c_msb, ovf_w, last;
    logic [DIGIT-1:0] res_digit;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a_digit  (a_q[DIGIT-1:0]),
        .b_digit  (b_q[DIGIT-1:0]),
        .cin      (carry),
        .op       (op_q),
        .res_digit(res_digit),
        .cout     (cout),
        .c_msb    (c_msb)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // result doubles as the shift register that collects digits from the top
    always_comb begin
        last      = cnt == CW'(N - 1);
        ovf_w     = cout ^ c_msb;
        final_res = op_q == ALUCTL_SLT ? WIDTH'(res_digit[DIGIT-1] ^ ovf_w)
                                       : {res_digit, result[WIDTH-1:DIGIT]};
        state_nx  = state;
        case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = (illegal || last) ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // an illegal code spends one RUN cycle so its result appears one edge after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry   <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= alucontrol;
                cnt     <= '0;
                carry   <= alucontrol[2];
                result  <= '0;
                zero    <= 1'b0;
                illegal <= !is_legal(alucontrol);
`ifdef ALU_OVF_EN
                ovf     <= 1'b0;
`endif
            end else if (state == RUN) begin
                if (illegal) begin
                    zero <= 1'b1;
                end else begin
                    a_q    <= a_q >> DIGIT;
                    b_q    <= b_q >> DIGIT;
                    carry  <= cout;
                    cnt    <= cnt + 1'b1;
                    result <= last ? final_res : {res_digit, result[WIDTH-1:DIGIT]};
                    if (last) zero <= final_res == '0;
`ifdef ALU_OVF_EN
                    if (last) ovf <= (op_q == ALUCTL_ADD || op_q == ALUCTL_SUB) && ovf_w;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: table-driven vectors plus backpressure and mid-RUN reset sequences for serial_alu.
module tb_serial_alu;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [2:0]  alucontrol;
    logic [31:0] a, b, result;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif
    int vecs = 0;
    int miss = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic        zero, ill, ovf;
    } vec_t;
    vec_t vt[14];

    serial_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alucontrol(alucontrol),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
`ifdef ALU_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // accept at the edge after setup; lat counts edges from accept until out_valid is seen
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, output int lat);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        alucontrol = op;
        a = x;
        b = y;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        alucontrol = 3'b101;
        a = '1;
        b = '1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int  lat;
        logic seen;
        vt[0]  = '{3'b010, 32'd5,        32'd7,        32'd12,       0, 0, 0};
        vt[1]  = '{3'b110, 32'd7,        32'd7,        32'd0,        1, 0, 0};
        vt[2]  = '{3'b111, 32'hFFFFFFF8, 32'd3,        32'd1,        0, 0, 0};
        vt[3]  = '{3'b111, 32'h80000000, 32'd1,        32'd1,        0, 0, 0};
        vt[4]  = '{3'b111, 32'd3,        32'd3,        32'd0,        1, 0, 0};
        vt[5]  = '{3'b011, 32'd9,        32'd9,        32'd0,        1, 1, 0};
        vt[6]  = '{3'b000, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 0, 0, 0};
        vt[7]  = '{3'b001, 32'h0F000001, 32'h10000010, 32'h1F000011, 0, 0, 0};
        vt[8]  = '{3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 0};
        vt[9]  = '{3'b110, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 0};
        vt[10] = '{3'b100, 32'd1,        32'd2,        32'd0,        1, 1, 0};
        vt[11] = '{3'b010, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0};
        vt[12] = '{3'b010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0, 1};
        vt[13] = '{3'b110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 0, 1};

        rst_n = 0;
        in_valid = 0;
        alucontrol = 0;
        a = 0;
        b = 0;
        out_ready = 1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_zero", 32'(zero), 0);
        check("rst_illegal", 32'(illegal), 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), vt[i].ill ? 1 : 8);
            check($sformatf("v%0d_result", i), result, vt[i].res);
            check($sformatf("v%0d_zero", i), 32'(zero), 32'(vt[i].zero));
            check($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vt[i].ill));
`ifdef ALU_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
`endif
            @(negedge clk);
            check($sformatf("v%0d_handshake", i), 32'(out_valid), 0);
        end

        out_ready = 0;
        do_op(3'b010, 32'd5, 32'd7, lat);
        check("bp_latency", 32'(lat), 8);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2) == 0;
            alucontrol = 3'b110;
            a = 32'd100;
            b = 32'd1;
            @(negedge clk);
            check($sformatf("bp%0d_result", k), result, 12);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 0);
            check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 1);
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("bp_no_stale_accept", 32'(in_ready), 1);

        alucontrol = 3'b010;
        a = 32'd5;
        b = 32'd7;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", 32'(zero), 0);
        check("mid_rst_illegal", 32'(illegal), 0);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("mid_rst_no_valid", 32'(seen), 0);
        do_op(3'b010, 32'd1, 32'd1, lat);
        check("post_rst_latency", 32'(lat), 8);
        check("post_rst_result", result, 2);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
